// File: rtl/fetch.sv
// Instruction fetch stage: issues one word read at a time, squashes wrong-path
// returns after a redirect, and parks a returned word while decode is stalled.
module fetch #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008,
    parameter logic [31:0] NOP_INST  = 32'h83FF_F800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc_plus_four,
    output logic        inst_valid
);

    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_KILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ppf_q, ppf_d;
    logic        inst_valid_q, inst_valid_d;

    logic        redirect;
    logic        emit;
    logic [31:0] emit_data;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        unused_bits;

    assign redirect    = (pc_sel >= 3'd1) && (pc_sel <= 3'd4);
    // Bit 31 selects the privileged half of the address space; increments never touch it.
    assign pc_inc      = {pc_q[31], pc_q[30:0] + 31'd4};
    assign unused_bits = ^{branch_addr[31], branch_addr[1:0], jump_addr[1:0]};

    always_comb begin
        target = pc_inc;
        case (pc_sel)
            3'd1:    target = {pc_q[31], branch_addr[30:2], 2'b00};
            3'd2:    target = {pc_q[31] & jump_addr[31], jump_addr[30:2], 2'b00};
            3'd3:    target = ILLOP_VEC;
            3'd4:    target = XADR_VEC;
            default: target = pc_inc;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        inst_d       = inst_q;
        ppf_d        = ppf_q;
        inst_valid_d = inst_valid_q;
        emit         = 1'b0;
        emit_data    = imem_rdata;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem_ack) state_d = ST_KILL;
                end else if (imem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                    if (redirect) begin
                        pc_d = target;
                    end else if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        emit = 1'b1;
                        pc_d = pc_inc;
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (redirect)    pc_d    = target;
                if (imem_rvalid) state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    emit      = 1'b1;
                    emit_data = hold_q;
                    pc_d      = pc_inc;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (redirect) begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
        end else if (emit) begin
            inst_d       = emit_data;
            ppf_d        = pc_inc;
            inst_valid_d = 1'b1;
        end else if (!stall) begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_VEC;
            hold_q       <= '0;
            inst_q       <= NOP_INST;
            ppf_q        <= RESET_VEC;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            inst_q       <= inst_d;
            ppf_q        <= ppf_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign pc_plus_four = ppf_q;
    assign inst_valid   = inst_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: a single-outstanding memory with random latency
// and stray rvalids, checked every cycle against a transaction-level model.
module tb_fetch;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
    localparam logic [31:0] NOP_INST  = 32'h83FF_F800;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_sel;
    logic [31:0] branch_addr, jump_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst, pc_plus_four;
    logic        inst_valid;

    fetch #(
        .RESET_VEC(RESET_VEC),
        .ILLOP_VEC(ILLOP_VEC),
        .XADR_VEC (XADR_VEC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .branch_addr (branch_addr),
        .jump_addr   (jump_addr),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc_plus_four(pc_plus_four),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a read is either in flight (possibly doomed by a redirect), parked, or neither.
    logic [31:0] m_pc, m_inst, m_ppf, m_park;
    bit          m_pending, m_squash, m_parked, m_valid;

    function automatic logic [31:0] seq_next(input logic [31:0] p);
        return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    task automatic model_reset();
        m_pc = RESET_VEC; m_inst = NOP_INST; m_ppf = RESET_VEC; m_valid = 0;
        m_pending = 0; m_squash = 0; m_parked = 0; m_park = '0;
    endtask

    task automatic model_step(input logic [2:0] sel, input logic [31:0] ba, input logic [31:0] ja,
                              input bit stl, input bit ack, input bit rv, input logic [31:0] rd);
        bit          redir, emit;
        logic [31:0] tgt, nxt, edata;
        redir = (sel >= 1) && (sel <= 4);
        nxt   = seq_next(m_pc);
        tgt   = nxt;
        if (sel == 1) tgt = (m_pc & 32'h8000_0000) | (ba & 32'h7FFF_FFFC);
        if (sel == 2) tgt = (m_pc & ja & 32'h8000_0000) | (ja & 32'h7FFF_FFFC);
        if (sel == 3) tgt = ILLOP_VEC;
        if (sel == 4) tgt = XADR_VEC;
        emit = 0; edata = rd;
        if (!m_pending && !m_parked) begin
            if (ack) begin m_pending = 1; m_squash = redir; end
            if (redir) m_pc = tgt;
        end else if (m_pending) begin
            if (m_squash) begin
                if (rv) m_pending = 0;
                if (redir) m_pc = tgt;
            end else if (rv) begin
                m_pending = 0;
                if (redir) m_pc = tgt;
                else if (stl) begin m_parked = 1; m_park = rd; end
                else begin emit = 1; m_pc = nxt; end
            end else if (redir) begin
                m_squash = 1; m_pc = tgt;
            end
        end else begin
            if (redir) begin m_parked = 0; m_pc = tgt; end
            else if (!stl) begin m_parked = 0; emit = 1; edata = m_park; m_pc = nxt; end
        end
        if (redir) begin m_inst = NOP_INST; m_valid = 0; end
        else if (emit) begin m_inst = edata; m_ppf = nxt; m_valid = 1; end
        else if (!stl) begin m_inst = NOP_INST; m_valid = 0; end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(7))
            0:       return 32'h7FFF_FFFC;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'h0000_0040;
            default: return $urandom;
        endcase
    endfunction

    bit          mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;

    initial begin
        bit          phase0;
        bit          rv, ack;
        logic [31:0] rd;

        rst = 1; pc_sel = 0; branch_addr = 0; jump_addr = 0; stall = 0;
        imem_ack = 0; imem_rvalid = 0; imem_rdata = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_req",   {31'b0, imem_req}, 32'd1);
        check_eq("rst_addr",  imem_addr, RESET_VEC);
        check_eq("rst_inst",  inst, NOP_INST);
        check_eq("rst_ppf",   pc_plus_four, RESET_VEC);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
        rst = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            phase0 = (cyc < 8);
            if (rst) rst = 0;

            check_eq("req",   {31'b0, imem_req}, {31'b0, !m_pending && !m_parked});
            if (!m_pending && !m_parked) check_eq("addr", imem_addr, m_pc);
            check_eq("inst",  inst, m_inst);
            check_eq("ppf",   pc_plus_four, m_ppf);
            check_eq("valid", {31'b0, inst_valid}, {31'b0, m_valid});

            // Zero-wait memory returning the address as data, no stall.
            if (phase0) begin
                if (cyc % 2 == 0) check_eq("zw_addr", imem_addr, RESET_VEC + 32'(cyc * 2));
                if (cyc >= 2 && cyc % 2 == 0) begin
                    check_eq("zw_inst", inst, RESET_VEC + 32'((cyc - 2) * 2));
                    check_eq("zw_ppf",  pc_plus_four, RESET_VEC + 32'((cyc - 2) * 2 + 4));
                end
                check_eq("zw_valid", {31'b0, inst_valid}, {31'b0, cyc >= 2 && cyc % 2 == 0});
            end

            rv = 0; rd = $urandom;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    rv = 1; mem_busy = 0;
                    if (phase0) rd = mem_addr;
                end else begin
                    mem_cnt--;
                end
            end else if (!phase0 && $urandom_range(9) == 0) begin
                rv = 1;
            end
            ack = 0;
            if (!mem_busy && imem_req && (phase0 || $urandom_range(99) < 60)) begin
                ack = 1; mem_busy = 1; mem_addr = imem_addr;
                mem_cnt = phase0 ? 0 : $urandom_range(3);
            end
            imem_rvalid = rv; imem_rdata = rd; imem_ack = ack;

            stall       = phase0 ? 1'b0 : ($urandom_range(99) < 30);
            pc_sel      = (phase0 || $urandom_range(99) < 80) ? 3'd0 : 3'($urandom_range(7));
            branch_addr = pick_addr();
            jump_addr   = pick_addr();

            if (!phase0 && $urandom_range(299) == 0) begin
                #1 rst = 1;
                #1;
                model_reset();
                check_eq("async_rst_addr",  imem_addr, RESET_VEC);
                check_eq("async_rst_valid", {31'b0, inst_valid}, 32'd0);
                check_eq("async_rst_inst",  inst, NOP_INST);
            end else begin
                model_step(pc_sel, branch_addr, jump_addr, stall, ack, rv, rd);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
